// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package dmem_pkg;

  // Responder control states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  localparam int WORD_BYTES = 4;
  localparam int LAT_W      = 4;

  // Word-aligned and inside the storage array
  function automatic logic addr_ok(input logic [31:0] addr, input logic [31:0] depth);
    return (addr[1:0] == 2'b00) && ({2'b00, addr[31:2]} < depth);
  endfunction

endpackage

// File: rtl/dmem_responder.sv
// Data-memory responder for MEM-stage load/store requests, with a preloadable word array DM.
// Latency: rsp_valid pulses LAT+1 cycles after acceptance; one request per LAT+2 cycles.
// Backpressure: req_ready low from acceptance until the response; no response backpressure.
// Optional byte-lane stores when DMEM_BYTE_STROBE_EN is defined (adds req_be).
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH  = 128,
  parameter int LAT    = 2,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
`ifdef DMEM_BYTE_STROBE_EN
  input  logic [3:0]        req_be,
`endif
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Storage array: deliberately not reset so bench preloads survive reset
  logic [DATA_W-1:0] DM [DEPTH];

  dmem_state_t       state, state_nxt;
  logic [LAT_W-1:0]  cnt, cnt_nxt;
  logic              accept;
  logic              enter_resp;

  logic              hold_we;
  logic [31:0]       hold_addr;
  logic [DATA_W-1:0] hold_wdata;
`ifdef DMEM_BYTE_STROBE_EN
  logic [3:0]        hold_be;
  logic [3:0]        commit_be;
`endif

  logic              commit_we;
  logic [31:0]       commit_addr;
  logic [DATA_W-1:0] commit_wdata;
  logic              commit_ok;
  logic [IDX_W-1:0]  commit_idx;
  logic [DATA_W-1:0] store_word;

  // Next-state, counter and handshake decode
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept = 1'b1;
          if (LAT == 0) begin
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = LAT_W'(LAT - 1);
          end
        end
      end
      WAIT: begin
        if (cnt == '0) state_nxt = RESP;
        else           cnt_nxt   = cnt - 1'b1;
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // RESP is always left after one cycle, so any transition into it is the commit edge
  assign enter_resp = (state_nxt == RESP) && (state != RESP);

  // With LAT==0 the commit edge is also the capture edge, so take the live request
  always_comb begin
    commit_we    = hold_we;
    commit_addr  = hold_addr;
    commit_wdata = hold_wdata;
`ifdef DMEM_BYTE_STROBE_EN
    commit_be    = hold_be;
`endif
    if (state == IDLE) begin
      commit_we    = req_we;
      commit_addr  = req_addr;
      commit_wdata = req_wdata;
`ifdef DMEM_BYTE_STROBE_EN
      commit_be    = req_be;
`endif
    end
  end

  assign commit_ok  = addr_ok(commit_addr, 32'(DEPTH));
  assign commit_idx = commit_addr[IDX_W+1:2];

  // Merge store data into the current word lane by lane (full word without strobes)
  always_comb begin
    store_word = commit_wdata;
`ifdef DMEM_BYTE_STROBE_EN
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (!commit_be[i]) store_word[8*i +: 8] = DM[commit_idx][8*i +: 8];
    end
`endif
  end

  // State, counter, holding registers and registered response fields
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      hold_we    <= 1'b0;
      hold_addr  <= '0;
      hold_wdata <= '0;
`ifdef DMEM_BYTE_STROBE_EN
      hold_be    <= '0;
`endif
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        hold_we    <= req_we;
        hold_addr  <= req_addr;
        hold_wdata <= req_wdata;
`ifdef DMEM_BYTE_STROBE_EN
        hold_be    <= req_be;
`endif
      end
      if (enter_resp) begin
        rsp_err   <= !commit_ok;
        rsp_rdata <= (!commit_we && commit_ok) ? DM[commit_idx] : '0;
      end else begin
        rsp_err   <= 1'b0;
        rsp_rdata <= '0;
      end
    end
  end

  // Store commit; a reset on the commit edge aborts the write
  always_ff @(posedge clk) begin
    if (rst && enter_resp && commit_we && commit_ok) DM[commit_idx] <= store_word;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one LAT=2 instance and one LAT=0 instance.
// Latency: checks response timing relative to the acceptance edge.
// Backpressure: checks req_ready low while a request is in flight.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];
`ifdef DMEM_BYTE_STROBE_EN
  logic [3:0]  req_be    [2];
  logic [3:0]  next_be;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(128), .LAT(2), .DATA_W(32)) u_lat2 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
`ifdef DMEM_BYTE_STROBE_EN
    .req_be(req_be[0]),
`endif
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  dmem_responder #(.DEPTH(128), .LAT(0), .DATA_W(32)) u_lat0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
`ifdef DMEM_BYTE_STROBE_EN
    .req_be(req_be[1]),
`endif
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  // Issue one request on instance d, scramble inputs after acceptance, and time the response
  task automatic issue(input int d, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       output int cyc, output logic [31:0] rd, output logic er, output logic rdy_leak);
    int n;
    @(negedge clk);
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
`ifdef DMEM_BYTE_STROBE_EN
    req_be[d]    = next_be;
`endif
    n = 0;
    while (!req_ready[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0;
    req_we[d]    = ~we;
    req_addr[d]  = $urandom;
    req_wdata[d] = $urandom;
`ifdef DMEM_BYTE_STROBE_EN
    req_be[d]    = 4'($urandom);
`endif
    cyc = -1; rd = '0; er = 1'b0; rdy_leak = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (req_ready[d]) rdy_leak = 1'b1;
      if (rsp_valid[d]) begin
        cyc = i;
        rd  = rsp_rdata[d];
        er  = rsp_err[d];
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (req_ready[0] !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", req_ready[0]); end
    total++; if (rsp_valid[0] !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid[0]); end
    total++; if (rsp_rdata[0] !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0", rsp_rdata[0]); end
    total++; if (rsp_err[0] !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", rsp_err[0]); end
    total++; if (u_lat2.DM[1] !== 32'd3) begin bad++; $display("FAIL reset_keeps_dm got=%h want=3", u_lat2.DM[1]); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_load();
    int cyc; logic [31:0] rd; logic er, leak;
    issue(0, 1'b0, 32'h4, 32'h0, cyc, rd, er, leak);
    total++; if (cyc != 3) begin bad++; $display("FAIL load_latency got=%0d want=3", cyc); end
    total++; if (rd !== 32'd3) begin bad++; $display("FAIL load_rdata got=%h want=3", rd); end
    total++; if (er !== 1'b0) begin bad++; $display("FAIL load_err got=%b want=0", er); end
    total++; if (leak !== 1'b0) begin bad++; $display("FAIL load_ready_low got=%b want=0", leak); end
  endtask

  task automatic test_store_load();
    int cyc; logic [31:0] rd; logic er, leak;
    issue(0, 1'b1, 32'h8, 32'h0000000B, cyc, rd, er, leak);
    total++; if (cyc != 3) begin bad++; $display("FAIL store_latency got=%0d want=3", cyc); end
    total++; if (rd !== 32'h0 || er !== 1'b0) begin bad++; $display("FAIL store_rsp got=%h/%b want=0/0", rd, er); end
    total++; if (u_lat2.DM[2] !== 32'hB) begin bad++; $display("FAIL store_dm got=%h want=b", u_lat2.DM[2]); end
    issue(0, 1'b0, 32'h8, 32'h0, cyc, rd, er, leak);
    total++; if (rd !== 32'hB) begin bad++; $display("FAIL store_then_load got=%h want=b", rd); end
  endtask

  task automatic test_errors();
    int cyc; logic [31:0] rd; logic er, leak;
    issue(0, 1'b0, 32'h2, 32'h0, cyc, rd, er, leak);
    total++; if (cyc != 3) begin bad++; $display("FAIL misalign_latency got=%0d want=3", cyc); end
    total++; if (er !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL misalign_rsp got=%h/%b want=0/1", rd, er); end
    issue(0, 1'b1, 32'h200, 32'h55, cyc, rd, er, leak);
    total++; if (er !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL oob_store_rsp got=%h/%b want=0/1", rd, er); end
    total++; if (u_lat2.DM[0] !== 32'hCAFE0000) begin bad++; $display("FAIL oob_store_dm got=%h want=cafe0000", u_lat2.DM[0]); end
    issue(0, 1'b0, 32'h1FC, 32'h0, cyc, rd, er, leak);
    total++; if (er !== 1'b0 || rd !== 32'h7F) begin bad++; $display("FAIL last_word got=%h/%b want=7f/0", rd, er); end
  endtask

  task automatic test_lat0();
    int cyc; logic [31:0] rd; logic er, leak;
    issue(1, 1'b0, 32'h0, 32'h0, cyc, rd, er, leak);
    total++; if (cyc != 1) begin bad++; $display("FAIL lat0_latency got=%0d want=1", cyc); end
    total++; if (rd !== 32'd9 || er !== 1'b0) begin bad++; $display("FAIL lat0_rsp got=%h/%b want=9/0", rd, er); end
    total++; if (leak !== 1'b0) begin bad++; $display("FAIL lat0_ready_low got=%b want=0", leak); end
  endtask

  // Hold req_valid high and record the cycles in which a handshake occurs
  task automatic test_back_to_back(input int d, input int period);
    int acc[$];
    @(negedge clk);
    req_valid[d] = 1'b1;
    req_we[d]    = 1'b0;
    req_addr[d]  = 32'h0;
    for (int c = 0; c < 4 * period + 1; c++) begin
      if (req_ready[d]) acc.push_back(c);
      @(negedge clk);
    end
    req_valid[d] = 1'b0;
    repeat (period + 2) @(negedge clk);
    total++; if (acc.size() != 5) begin bad++; $display("FAIL b2b_count inst=%0d got=%0d want=5", d, acc.size()); end
    for (int i = 1; i < acc.size(); i++) begin
      total++;
      if (acc[i] - acc[i-1] != period) begin
        bad++; $display("FAIL b2b_spacing inst=%0d got=%0d want=%0d", d, acc[i] - acc[i-1], period);
      end
    end
  endtask

  // Reset asserted in cycle 'when' after acceptance (1 = in WAIT, 2 = on the edge entering RESP)
  task automatic test_reset_mid(input int when);
    logic seen;
    u_lat2.DM[3] = 32'h12345678;
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b1;
    req_addr[0]  = 32'hC;
    req_wdata[0] = 32'hFF;
`ifdef DMEM_BYTE_STROBE_EN
    req_be[0]    = 4'hF;
`endif
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    repeat (when) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    seen = rsp_valid[0];
    total++; if (req_ready[0] !== 1'b1) begin bad++; $display("FAIL midrst_ready when=%0d got=%b want=1", when, req_ready[0]); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid[0]) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL midrst_no_rsp when=%0d got=%b want=0", when, seen); end
    total++; if (u_lat2.DM[3] !== 32'h12345678) begin bad++; $display("FAIL midrst_dm when=%0d got=%h want=12345678", when, u_lat2.DM[3]); end
  endtask

`ifdef DMEM_BYTE_STROBE_EN
  task automatic test_byte_strobe();
    int cyc; logic [31:0] rd; logic er, leak;
    u_lat2.DM[0] = 32'h11223344;
    next_be = 4'b0101;
    issue(0, 1'b1, 32'h0, 32'hAABBCCDD, cyc, rd, er, leak);
    total++; if (u_lat2.DM[0] !== 32'h11BB33DD) begin bad++; $display("FAIL be_merge got=%h want=11bb33dd", u_lat2.DM[0]); end
    next_be = 4'b0000;
    issue(0, 1'b1, 32'h0, 32'hFFFFFFFF, cyc, rd, er, leak);
    total++; if (u_lat2.DM[0] !== 32'h11BB33DD || er !== 1'b0) begin bad++; $display("FAIL be_noop got=%h/%b want=11bb33dd/0", u_lat2.DM[0], er); end
    next_be = 4'hF;
  endtask
`endif

  initial begin
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0;
      req_we[d]    = 1'b0;
      req_addr[d]  = '0;
      req_wdata[d] = '0;
`ifdef DMEM_BYTE_STROBE_EN
      req_be[d]    = 4'hF;
`endif
    end
`ifdef DMEM_BYTE_STROBE_EN
    next_be = 4'hF;
`endif
    u_lat2.DM[0]   = 32'hCAFE0000;
    u_lat2.DM[1]   = 32'd3;
    u_lat2.DM[2]   = 32'h0;
    u_lat2.DM[127] = 32'h7F;
    u_lat0.DM[0]   = 32'd9;

    test_reset();
    test_single_load();
    test_store_load();
    test_errors();
    test_lat0();
    test_back_to_back(0, 4);
    test_back_to_back(1, 2);
    test_reset_mid(1);
    test_reset_mid(2);
`ifdef DMEM_BYTE_STROBE_EN
    test_byte_strobe();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
